// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among N_REQ packet sources.
// Optional stall watchdog on the granted source: define UART_ARB_WDOG_EN.
module uart_tx_arbiter #(
  parameter int N_REQ       = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [N_REQ-1:0]     grant,
  output logic                 wdog_abort
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, ACK, DONE} state_t;

  state_t           state, state_n;
  logic [N_REQ-1:0] grant_n;
  logic [IW-1:0]    rr_ptr, rr_ptr_n;
  logic [IW-1:0]    gidx, gidx_n;
  logic             tx_start_n;
  logic [7:0]       tx_data_n;
  logic             last_q, last_n;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;

`ifdef UART_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES) + 1;
  logic [WW-1:0] wcnt, wcnt_n;
  logic          abort_n;
`endif

  // First requester strictly after the last owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign g_valid = req_valid[gidx];
  assign g_last  = req_last[gidx];
  assign g_data  = req_data[int'(gidx)*8 +: 8];

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    rr_ptr_n   = rr_ptr;
    gidx_n     = gidx;
    tx_start_n = 1'b0;
    tx_data_n  = tx_data;
    last_n     = last_q;
    req_ready  = '0;
`ifdef UART_ARB_WDOG_EN
    wcnt_n     = '0;
    abort_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!tx_busy && pick_found) begin
          grant_n = N_REQ'(1) << pick_idx;
          gidx_n  = pick_idx;
          state_n = SEND;
        end
      end
      SEND: begin
        req_ready = grant & req_valid;
        if (g_valid) begin
          tx_data_n  = g_data;
          last_n     = g_last;
          tx_start_n = 1'b1;
          state_n    = ACK;
        end
`ifdef UART_ARB_WDOG_EN
        else if (wcnt == WW'(WDOG_CYCLES - 1)) begin
          grant_n  = '0;
          rr_ptr_n = gidx;
          abort_n  = 1'b1;
          state_n  = IDLE;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
`endif
      end
      ACK: begin
        if (tx_busy) state_n = DONE;
      end
      DONE: begin
        // Frame finished: either release the source or fetch its next byte.
        if (!tx_busy) begin
          if (last_q) begin
            grant_n  = '0;
            rr_ptr_n = gidx;
            state_n  = IDLE;
          end else begin
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= IW'(N_REQ - 1);
      gidx     <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      last_q   <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      rr_ptr   <= rr_ptr_n;
      gidx     <= gidx_n;
      tx_start <= tx_start_n;
      tx_data  <= tx_data_n;
      last_q   <= last_n;
    end
  end

`ifdef UART_ARB_WDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt       <= '0;
      wdog_abort <= 1'b0;
    end else begin
      wcnt       <= wcnt_n;
      wdog_abort <= abort_n;
    end
  end
`else
  assign wdog_abort = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: cycle table with hand-driven busy, then packet sequences
// against a TX engine model (busy 1 cycle after tx_start, high for 20 cycles).
module tb_uart_tx_arbiter;

  localparam int WD = 16;

  typedef struct {
    logic       rst;
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] last;
    logic       busy;
    logic [1:0] e_grant;
    logic [1:0] e_ready;
    logic       e_start;
    logic [7:0] e_txd;
    logic       chk_txd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic        tx_start, tx_busy, wdog_abort;
  logic [7:0]  tx_data;

  logic        model_en = 1'b0;
  logic [1:0]  tbl_valid = '0, tbl_last = '0;
  logic [15:0] tbl_data = '0;
  logic        tbl_busy = 1'b0;
  logic [1:0]  feed_valid = '0, feed_last = '0;
  logic [15:0] feed_data = '0;
  int          busy_cnt = 0;

  logic [8:0]  src_buf [2][64];
  int          head [2] = '{0, 0};
  int          tail [2] = '{0, 0};
  logic [7:0]  log_data [64];
  logic [1:0]  log_grant [64];
  int          log_cnt = 0;

  int          n_checks = 0;
  int          n_pass = 0;
  vec_t        vecs [30];

  assign req_valid = model_en ? feed_valid : tbl_valid;
  assign req_data  = model_en ? feed_data  : tbl_data;
  assign req_last  = model_en ? feed_last  : tbl_last;
  assign tx_busy   = model_en ? (busy_cnt != 0) : tbl_busy;

  uart_tx_arbiter #(.N_REQ(2), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .wdog_abort(wdog_abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (model_en && tx_start) busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Sources pop a byte on each accepted handshake and present the next one at the falling edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (model_en && req_ready[i]) head[i] <= head[i] + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (head[i] < tail[i]) begin
        feed_valid[i]        = 1'b1;
        feed_data[8*i +: 8]  = src_buf[i][head[i]][7:0];
        feed_last[i]         = src_buf[i][head[i]][8];
      end else begin
        feed_valid[i] = 1'b0;
        feed_last[i]  = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (model_en && tx_start && log_cnt < 64) begin
      log_data[log_cnt]  <= tx_data;
      log_grant[log_cnt] <= grant;
      log_cnt            <= log_cnt + 1;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(logic r, logic [1:0] v, logic [7:0] d0, logic [7:0] d1,
                              logic [1:0] l, logic b, logic [1:0] eg, logic [1:0] er,
                              logic es, logic [7:0] ed, logic ck);
    vec_t x;
    x.rst = r; x.valid = v; x.d0 = d0; x.d1 = d1; x.last = l; x.busy = b;
    x.e_grant = eg; x.e_ready = er; x.e_start = es; x.e_txd = ed; x.chk_txd = ck;
    return x;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    tbl_valid = v.valid;
    tbl_data  = {v.d1, v.d0};
    tbl_last  = v.last;
    tbl_busy  = v.busy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    src_buf[s][tail[s]] = {l, d};
    tail[s]++;
  endtask

  task automatic doReset();
    tail[0] = head[0];
    tail[1] = head[1];
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitDrain(input int maxc, input string nm);
    int n = 0;
    while (!(head[0] == tail[0] && head[1] == tail[1] && grant == 2'b00 && !tx_busy) && n < maxc) begin
      tick();
      n++;
    end
    checkOutput(nm, 32'(n >= maxc), 32'd0);
  endtask

  task automatic waitBusy(input logic lvl, input int maxc, input string nm);
    int n = 0;
    while (tx_busy !== lvl && n < maxc) begin
      tick();
      n++;
    end
    checkOutput(nm, 32'(tx_busy), 32'(lvl));
  endtask

  initial begin
    int base;
    logic bad;
    logic [7:0] exp_d [5];
    logic [1:0] exp_g [5];

    vecs[0]  = mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00, 1);
    vecs[1]  = mk(0, 2'b01, 8'h41, 8'h00, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00, 1);
    vecs[2]  = mk(0, 2'b01, 8'h41, 8'h00, 2'b00, 0, 2'b01, 2'b01, 0, 8'h00, 0);
    vecs[3]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b01, 2'b00, 1, 8'h41, 1);
    vecs[4]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b01, 2'b00, 0, 8'h41, 1);
    vecs[5]  = mk(0, 2'b01, 8'h42, 8'h00, 2'b01, 1, 2'b01, 2'b00, 0, 8'h41, 1);
    vecs[6]  = mk(0, 2'b01, 8'h42, 8'h00, 2'b01, 0, 2'b01, 2'b00, 0, 8'h41, 0);
    vecs[7]  = mk(0, 2'b01, 8'h42, 8'h00, 2'b01, 0, 2'b01, 2'b01, 0, 8'h41, 0);
    vecs[8]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b01, 2'b00, 1, 8'h42, 1);
    vecs[9]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b01, 2'b00, 0, 8'h42, 1);
    vecs[10] = mk(0, 2'b10, 8'h00, 8'h55, 2'b10, 0, 2'b01, 2'b00, 0, 8'h42, 0);
    vecs[11] = mk(0, 2'b10, 8'h00, 8'h55, 2'b10, 0, 2'b00, 2'b00, 0, 8'h42, 0);
    vecs[12] = mk(0, 2'b11, 8'h77, 8'h55, 2'b10, 0, 2'b10, 2'b10, 0, 8'h42, 0);
    vecs[13] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b10, 2'b00, 1, 8'h55, 1);
    vecs[14] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b10, 2'b00, 0, 8'h55, 1);
    vecs[15] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b10, 2'b00, 0, 8'h55, 0);
    vecs[16] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 2'b00, 0, 8'h55, 0);
    vecs[17] = mk(0, 2'b11, 8'h00, 8'h00, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0);
    vecs[18] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00, 0);
    vecs[19] = mk(0, 2'b11, 8'h00, 8'h00, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00, 0);
    vecs[20] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b01, 2'b00, 0, 8'h00, 0);
    vecs[21] = mk(1, 2'b01, 8'h00, 8'h00, 2'b00, 1, 2'b01, 2'b01, 0, 8'h00, 0);
    vecs[22] = mk(0, 2'b01, 8'h00, 8'h00, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 1);
    vecs[23] = mk(0, 2'b01, 8'h00, 8'h00, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 1);
    vecs[24] = mk(0, 2'b01, 8'h00, 8'h00, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00, 1);
    vecs[25] = mk(0, 2'b01, 8'h99, 8'h00, 2'b01, 0, 2'b01, 2'b01, 0, 8'h00, 1);
    vecs[26] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b01, 2'b00, 1, 8'h99, 1);
    vecs[27] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b01, 2'b00, 0, 8'h99, 1);
    vecs[28] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b01, 2'b00, 0, 8'h99, 1);
    vecs[29] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 2'b00, 0, 8'h99, 0);

    rst = 1'b1;
    tick();
    tick();

    for (int r = 0; r < 30; r++) begin
      applyStimulus(vecs[r]);
      checkOutput($sformatf("row%0d grant", r), 32'(grant), 32'(vecs[r].e_grant));
      checkOutput($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(vecs[r].e_ready));
      checkOutput($sformatf("row%0d tx_start", r), 32'(tx_start), 32'(vecs[r].e_start));
      checkOutput($sformatf("row%0d wdog_abort", r), 32'(wdog_abort), 32'd0);
      if (vecs[r].chk_txd)
        checkOutput($sformatf("row%0d tx_data", r), 32'(tx_data), 32'(vecs[r].e_txd));
    end

    // Valid pulsed for one cycle in IDLE while the engine is busy.
    tick();
    tbl_busy  = 1'b1;
    tbl_valid = 2'b01;
    tick();
    tbl_valid = 2'b00;
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) tbl_busy = 1'b0;
      if (grant !== 2'b00 || tx_start !== 1'b0) bad = 1'b1;
      tick();
    end
    checkOutput("busy_pulse no_grant", 32'(bad), 32'd0);
    checkOutput("busy_pulse final_grant", 32'(grant), 32'd0);

    model_en = 1'b1;

    // Three-byte packet from source 0.
    doReset();
    base = log_cnt;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    waitDrain(300, "pkt3 drain_timeout");
    repeat (25) tick();
    checkOutput("pkt3 start_count", 32'(log_cnt - base), 32'd3);
    exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("pkt3 byte%0d", i), 32'(log_data[base+i]), 32'(exp_d[i]));
      checkOutput($sformatf("pkt3 grant%0d", i), 32'(log_grant[base+i]), 32'(2'b01));
    end
    checkOutput("pkt3 grant_after", 32'(grant), 32'd0);

    // Simultaneous requests after reset, then again after source 1 owned last.
    doReset();
    base = log_cnt;
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b1);
    waitDrain(400, "simul drain_timeout");
    push(0, 8'hC0, 1'b1);
    push(1, 8'hD0, 1'b1);
    waitDrain(300, "simul2 drain_timeout");
    checkOutput("simul start_count", 32'(log_cnt - base), 32'd5);
    exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hB0; exp_d[3] = 8'hC0; exp_d[4] = 8'hD0;
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01; exp_g[4] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("simul byte%0d", i), 32'(log_data[base+i]), 32'(exp_d[i]));
      checkOutput($sformatf("simul grant%0d", i), 32'(log_grant[base+i]), 32'(exp_g[i]));
    end

    // Source 1 streams 1-byte packets while source 0 competes: strict alternation.
    doReset();
    base = log_cnt;
    push(1, 8'hE0, 1'b1);
    push(1, 8'hE1, 1'b1);
    push(1, 8'hE2, 1'b1);
    repeat (3) tick();
    push(0, 8'hF0, 1'b1);
    push(0, 8'hF1, 1'b1);
    waitDrain(600, "alt drain_timeout");
    checkOutput("alt start_count", 32'(log_cnt - base), 32'd5);
    exp_d[0] = 8'hE0; exp_d[1] = 8'hF0; exp_d[2] = 8'hE1; exp_d[3] = 8'hF1; exp_d[4] = 8'hE2;
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01; exp_g[4] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("alt byte%0d", i), 32'(log_data[base+i]), 32'(exp_d[i]));
      checkOutput($sformatf("alt grant%0d", i), 32'(log_grant[base+i]), 32'(exp_g[i]));
    end

    // Reset in the middle of a packet while a frame is still shifting.
    doReset();
    push(0, 8'h31, 1'b0);
    push(0, 8'h32, 1'b0);
    push(0, 8'h33, 1'b1);
    waitBusy(1'b1, 50, "midrst busy_rise");
    repeat (3) tick();
    tail[0] = head[0];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst grant", 32'(grant), 32'd0);
    checkOutput("midrst tx_start", 32'(tx_start), 32'd0);
    checkOutput("midrst tx_data", 32'(tx_data), 32'h00);
    checkOutput("midrst wdog_abort", 32'(wdog_abort), 32'd0);
    checkOutput("midrst still_busy", 32'(tx_busy), 32'd1);
    base = log_cnt;
    push(0, 8'h5A, 1'b1);
    bad = 1'b0;
    for (int n = 0; n < 30 && tx_busy; n++) begin
      if (grant !== 2'b00) bad = 1'b1;
      tick();
    end
    checkOutput("midrst no_grant_while_busy", 32'(bad), 32'd0);
    waitDrain(200, "midrst drain_timeout");
    checkOutput("midrst start_count", 32'(log_cnt - base), 32'd1);
    checkOutput("midrst byte", 32'(log_data[base]), 32'h5A);
    checkOutput("midrst byte_grant", 32'(log_grant[base]), 32'(2'b01));

    // Granted source stalls after a non-last byte while source 1 waits.
    doReset();
    base = log_cnt;
    push(0, 8'h11, 1'b0);
    push(1, 8'h22, 1'b1);
    waitBusy(1'b1, 50, "stall busy_rise");
    waitBusy(1'b0, 50, "stall busy_fall");
`ifdef UART_ARB_WDOG_EN
    bad = 1'b0;
    for (int j = 1; j <= WD; j++) begin
      tick();
      if (wdog_abort !== 1'b0 || grant !== 2'b01) bad = 1'b1;
    end
    checkOutput("wdog quiet_window", 32'(bad), 32'd0);
    tick();
    checkOutput("wdog abort_pulse", 32'(wdog_abort), 32'd1);
    checkOutput("wdog grant_released", 32'(grant), 32'd0);
    tick();
    checkOutput("wdog abort_single", 32'(wdog_abort), 32'd0);
    checkOutput("wdog next_grant", 32'(grant), 32'(2'b10));
    waitDrain(200, "wdog drain_timeout");
    checkOutput("wdog start_count", 32'(log_cnt - base), 32'd2);
    checkOutput("wdog src1_byte", 32'(log_data[base+1]), 32'h22);
    checkOutput("wdog src1_grant", 32'(log_grant[base+1]), 32'(2'b10));
`else
    bad = 1'b0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (wdog_abort !== 1'b0 || grant !== 2'b01) bad = 1'b1;
    end
    checkOutput("stall grant_held", 32'(bad), 32'd0);
    checkOutput("stall start_count", 32'(log_cnt - base), 32'd1);
    checkOutput("stall src0_byte", 32'(log_data[base]), 32'h11);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
